// File: rtl/naive_bus_sram_slave_pkg.sv
// Shared naive_bus types and constants for the SRAM responder.
package naive_bus_pkg;

    localparam int BUS_DW  = 32;
    localparam int BUS_BEW = 4;

    typedef enum logic {
        READY = 1'b0,
        BUSY  = 1'b1
    } slave_state_e;

    // Expand a byte-enable vector into a per-bit mask.
    function automatic logic [BUS_DW-1:0] be_to_mask(input logic [BUS_BEW-1:0] be);
        logic [BUS_DW-1:0] mask;
        mask = '0;
        for (int i = 0; i < BUS_BEW; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/naive_bus_sram_slave_if.sv
// naive_bus: split read/write request-grant bus between core masters and responders.
interface naive_bus;
    import naive_bus_pkg::*;

    logic                rd_req;
    logic [BUS_BEW-1:0]  rd_be;
    logic [31:0]         rd_addr;
    logic                rd_gnt;
    logic [BUS_DW-1:0]   rd_data;
    logic                wr_req;
    logic [BUS_BEW-1:0]  wr_be;
    logic [31:0]         wr_addr;
    logic [BUS_DW-1:0]   wr_data;
    logic                wr_gnt;

    modport master (
        output rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        input  rd_gnt, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_be, rd_addr, wr_req, wr_be, wr_addr, wr_data,
        output rd_gnt, rd_data, wr_gnt
    );

endinterface

// File: rtl/naive_bus_sram_slave_sram_be_1rw.sv
// Single-port word SRAM with byte-lane writes and a registered read port.
// The array and the read register carry no reset.
module sram_be_1rw
    import naive_bus_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_idx,
    output logic [BUS_DW-1:0]    rd_word,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_idx,
    input  logic [BUS_BEW-1:0]   wr_be,
    input  logic [BUS_DW-1:0]    wr_data
);

    logic [BUS_DW-1:0] mem_q [2**ADDR_BITS];
    logic [BUS_DW-1:0] rd_word_q;

    // Commit enabled byte lanes and capture the addressed word on a read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BUS_BEW; i++) begin
                if (wr_be[i]) begin
                    mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (rd_en) begin
            rd_word_q <= mem_q[rd_idx];
        end
    end

    assign rd_word = rd_word_q;

endmodule

// File: rtl/naive_bus_sram_slave.sv
// naive_bus SRAM responder: grant arbitration, wait-state FSM and read-data masking.
//
//   state | meaning
//   READY | grants may fire this cycle
//   BUSY  | wait window after a grant, all grants withheld
module naive_bus_sram_slave
    import naive_bus_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_CYCLES = 0,
    parameter int RD_PRIORITY = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    naive_bus.slave  bus_slave
);

    localparam logic       RD_WINS = (RD_PRIORITY != 0);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    slave_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [BUS_DW-1:0] mask_q, mask_d;
    logic              rd_gnt, wr_gnt;
    logic [BUS_DW-1:0] sram_word;

    // Address bits outside the word index are deliberately ignored (aliasing).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus_slave.rd_addr[31:ADDR_BITS+2], bus_slave.rd_addr[1:0],
                                bus_slave.wr_addr[31:ADDR_BITS+2], bus_slave.wr_addr[1:0]};

    // Arbitrate requests and sequence the wait window.
    always_comb begin
        rd_gnt  = 1'b0;
        wr_gnt  = 1'b0;
        state_d = state_q;
        cnt_d   = cnt_q;
        mask_d  = mask_q;
        case (state_q)
            READY: begin
                rd_gnt = bus_slave.rd_req & ~(bus_slave.wr_req & ~RD_WINS);
                wr_gnt = bus_slave.wr_req & ~(bus_slave.rd_req &  RD_WINS);
                if ((rd_gnt || wr_gnt) && (WAIT_LD != 4'd0)) begin
                    state_d = BUSY;
                    cnt_d   = WAIT_LD;
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = READY;
                end
            end
            default: state_d = READY;
        endcase
        // The mask only changes on a granted read, so rd_data holds otherwise.
        if (rd_gnt) begin
            mask_d = be_to_mask(bus_slave.rd_be);
        end
    end

    // State, counter and read mask; a cleared mask forces rd_data to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= READY;
            cnt_q   <= 4'd0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
        end
    end

    sram_be_1rw #(
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clk     (clk),
        .rd_en   (rd_gnt),
        .rd_idx  (bus_slave.rd_addr[ADDR_BITS+1:2]),
        .rd_word (sram_word),
        .wr_en   (wr_gnt),
        .wr_idx  (bus_slave.wr_addr[ADDR_BITS+1:2]),
        .wr_be   (bus_slave.wr_be),
        .wr_data (bus_slave.wr_data)
    );

    assign bus_slave.rd_gnt  = rd_gnt;
    assign bus_slave.wr_gnt  = wr_gnt;
    assign bus_slave.rd_data = sram_word & mask_q;

endmodule
